fp_mult_collect: RTL
====================

# fp_mult_collect

Downstream collection stage for the single-precision multiplier `fp_mult`. It tracks each product issued to the multiplier through a valid delay line matched to the multiplier latency, then captures the result word `y` when it emerges. Each result is classified (zero, subnormal, normal, infinity, quiet NaN, signalling NaN) and queued in a small FIFO with a valid/ready output. Credit-based back-pressure toward the issuer guarantees that no product is ever lost.

## Interface
- `MULT_LATENCY`, default 2: cycles from operands presented to `fp_mult` until `y` is valid; legal range 1..8.
- `FIFO_DEPTH`, default 4: result queue entries; power of two, 2..16.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: operands are being driven to `fp_mult` this cycle.
- `issue_ready`, output, 1: a new issue will be accepted this cycle.
- `y`, input, 32: `fp_mult` result, IEEE-754 binary32.
- `out_valid`, output, 1: FIFO head is valid.
- `out_ready`, input, 1: consumer accepts the head.
- `out_data`, output, 32: result word at the FIFO head.
- `out_class`, output, 3: class code of the head entry.
- `exc_count`, output, 8: saturating count of inf/NaN results captured.
- `exc_clr`, input, 1: synchronous clear of `exc_count`.
- `drop`, output, 1: sticky flag; set when `in_valid` was asserted while `issue_ready` was low.

## Operation
- Issue is accepted when `in_valid && issue_ready`. An accepted issue shifts a 1 into the `MULT_LATENCY`-deep valid delay line; a cycle without an accepted issue shifts in 0.
- Capture: when the last stage of the delay line is 1, sample `y` and its class into the FIFO tail on that edge.
- Class codes:
  - 0 = zero: exp==0, frac==0.
  - 1 = subnormal: exp==0, frac!=0.
  - 2 = normal.
  - 3 = inf: exp==255, frac==0.
  - 4 = qNaN: exp==255, frac[22]==1.
  - 5 = sNaN: exp==255, frac[22]==0, frac!=0.
  - Sign is ignored for classification.
- `exc_count` increments by 1 on each capture with class 3, 4 or 5, and saturates at 255. If `exc_clr` and a qualifying capture occur in the same cycle, clear wins and the result is 0.
- Credits: inflight = number of 1s in the delay line; occ = FIFO occupancy. `issue_ready` = (occ + inflight) < `FIFO_DEPTH`, computed combinationally from registered state only, never from `in_valid`.
- An issue while `issue_ready` is low is not tracked and sets `drop`. `drop` clears only on reset.
- Pop occurs on `out_valid && out_ready`. A push and a pop in the same cycle leave occupancy unchanged. The credit rule makes a push into a full FIFO impossible.
- The FIFO uses wrap-around read/write pointers of log2(`FIFO_DEPTH`)+1 bits; full/empty are derived from the MSB compare.

## Timing
- Reset (asynchronous assert, synchronous release): delay line = 0, FIFO empty, `out_valid`=0, `out_data`=0, `out_class`=0, `exc_count`=0, `drop`=0, `issue_ready`=1.
- Issue at edge t → capture at edge t+`MULT_LATENCY` → `out_valid`=1 after that edge. Minimum issue-to-`out_valid` latency is `MULT_LATENCY` cycles.
- With `out_ready` held high, throughput is 1 result per cycle with no bubbles.
- `out_data`/`out_class` are registered FIFO outputs and are stable while `out_valid && !out_ready`.
- Reset asserted mid-operation discards in-flight products and queued results. Results returned by `fp_mult` after reset release are ignored.

## Structure
- Shared package `fp_pkg` holds:
  - Localparams `FP_EXP_MAX`=8'hFF and `FP_FRAC_W`=23.
  - The class code constants `FPC_ZERO` … `FPC_SNAN`.
  - A classify function, reused by other stages.
- One sub-module, `fp_result_fifo`: parameterised depth, 35-bit payload (data + class), valid/ready on the read side, plus a push strobe and an occupancy output.
- The delay line, credit logic and counter live in the top module.

## Test plan
- Single issue, `MULT_LATENCY`=2, `y`=32'h40C00000 at edge t+2 → `out_valid` after t+2, `out_data`=32'h40C00000, `out_class`=2, `exc_count`=0.
- Back-to-back issues of 32'h00000000, 32'h00000001, 32'h7F800000, 32'h7FC00000, 32'h7F800001 → classes 0, 1, 3, 4, 5 in order; `exc_count`=3.
- `out_ready`=0 with `in_valid` held high → exactly 4 issues accepted, `issue_ready` falls while inflight products are still pending, and 1 further issue sets `drop`=1. Then set `out_ready`=1 → 4 results drain in order and `issue_ready` returns to 1.
- Simultaneous push and pop at occupancy 2 for 10 cycles → occupancy stays 2 and data order is preserved.
- 300 NaN captures → `exc_count`=255. Assert `exc_clr` in the same cycle as a NaN capture → `exc_count`=0.
- Assert `rst_n`=0 with 2 products in flight and 3 queued → all outputs at reset values immediately. After release, no result appears even though `y` still toggles.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared binary32 definitions: field limits, result class codes
//            and a classification helper used by the floating-point stages.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam logic [7:0] FP_EXP_MAX = 8'hFF;
    localparam int         FP_FRAC_W  = 23;
    localparam int         FP_WORD_W  = 32;
    localparam int         FP_CLASS_W = 3;

    localparam logic [FP_CLASS_W-1:0] FPC_ZERO = 3'd0;
    localparam logic [FP_CLASS_W-1:0] FPC_SUBN = 3'd1;
    localparam logic [FP_CLASS_W-1:0] FPC_NORM = 3'd2;
    localparam logic [FP_CLASS_W-1:0] FPC_INF  = 3'd3;
    localparam logic [FP_CLASS_W-1:0] FPC_QNAN = 3'd4;
    localparam logic [FP_CLASS_W-1:0] FPC_SNAN = 3'd5;

    // Sign is deliberately ignored: +0/-0 and +inf/-inf share a class.
    function automatic logic [FP_CLASS_W-1:0] fp_classify(input logic [FP_WORD_W-1:0] v);
        logic [7:0]           exp_f;
        logic [FP_FRAC_W-1:0] frac_f;
        logic [FP_CLASS_W-1:0] cls;
        exp_f  = v[30:23];
        frac_f = v[FP_FRAC_W-1:0];
        if (exp_f == 8'h00) begin
            cls = (frac_f == '0) ? FPC_ZERO : FPC_SUBN;
        end else if (exp_f != FP_EXP_MAX) begin
            cls = FPC_NORM;
        end else if (frac_f == '0) begin
            cls = FPC_INF;
        end else if (frac_f[FP_FRAC_W-1]) begin
            cls = FPC_QNAN;
        end else begin
            cls = FPC_SNAN;
        end
        return cls;
    endfunction

    // Infinities and both NaN flavours count as exceptional results.
    function automatic logic fp_is_exc(input logic [FP_CLASS_W-1:0] cls);
        return (cls == FPC_INF) || (cls == FPC_QNAN) || (cls == FPC_SNAN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fp_result_fifo
// Purpose  : Small synchronous FIFO for classified results.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            i_push, i_push_data - write strobe and payload
//            o_valid, i_ready    - read-side handshake (pop on both high)
//            o_data              - head entry, held while not popped
//            o_occ               - current number of stored entries
// Revision : 1.0 - initial release
// ============================================================================
module fp_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_occ
);

    localparam int                  c_addr_w  = $clog2(DEPTH);
    localparam logic [c_addr_w:0]   c_ptr_one = 1;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_addr_w:0] r_wr_ptr;
    logic [c_addr_w:0] r_rd_ptr;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // addresses with differing wrap bits mean full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                     (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);
    assign w_push  = i_push && !w_full;
    assign w_pop   = !w_empty && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_push_data;
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Head is read straight out of storage registers, so it only moves on a
    // pop and reads as zero after reset.
    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rd_ptr[c_addr_w-1:0]];
    assign o_occ   = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/fp_mult_collect.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_collect
// Purpose  : Collects fp_mult results: tracks issued products through a valid
//            delay line, classifies each result on capture and queues it with
//            valid/ready output. Credit back-pressure keeps every tracked
//            product guaranteed a FIFO slot.
// Ports    : clk, rst_n               - clock, asynchronous active-low reset
//            in_valid, issue_ready    - issue handshake toward the issuer
//            y                        - fp_mult result word
//            out_valid/out_ready      - result handshake
//            out_data, out_class      - head result and its class code
//            exc_count, exc_clr       - saturating inf/NaN counter and clear
//            drop                     - sticky lost-issue flag
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_collect
    import fp_pkg::*;
#(
    parameter int MULT_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  issue_ready,
    input  logic [FP_WORD_W-1:0]  y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FP_WORD_W-1:0]  out_data,
    output logic [FP_CLASS_W-1:0] out_class,
    output logic [7:0]            exc_count,
    input  logic                  exc_clr,
    output logic                  drop
);

    localparam int                 c_occ_w   = $clog2(FIFO_DEPTH) + 1;
    localparam int                 c_sum_w   = 6;
    localparam int                 c_entry_w = FP_CLASS_W + FP_WORD_W;
    localparam logic [c_sum_w-1:0] c_depth   = FIFO_DEPTH[c_sum_w-1:0];
    localparam logic [7:0]         c_exc_max = 8'hFF;

    logic [MULT_LATENCY-1:0] r_vld_pipe;
    logic [7:0]              r_exc_count;
    logic                    r_drop;

    logic                    w_accept;
    logic                    w_capture;
    logic [FP_CLASS_W-1:0]   w_class;
    logic [c_sum_w-1:0]      w_inflight;
    logic [c_occ_w-1:0]      w_occ;
    logic [c_sum_w-1:0]      w_credit_used;
    logic [c_entry_w-1:0]    w_head;

    // Every product in the delay line already owns a FIFO slot, so only
    // registered state is counted and the decision never depends on in_valid.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < MULT_LATENCY; i++) begin
            w_inflight = w_inflight + {{(c_sum_w-1){1'b0}}, r_vld_pipe[i]};
        end
    end

    assign w_credit_used = {{(c_sum_w-c_occ_w){1'b0}}, w_occ} + w_inflight;
    assign issue_ready   = (w_credit_used < c_depth);
    assign w_accept      = in_valid && issue_ready;
    assign w_capture     = r_vld_pipe[MULT_LATENCY-1];
    assign w_class       = fp_classify(y);

    generate
        if (MULT_LATENCY == 1) begin : g_lat_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld_pipe <= '0;
                end else begin
                    r_vld_pipe <= w_accept;
                end
            end
        end else begin : g_lat_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld_pipe <= '0;
                end else begin
                    r_vld_pipe <= {r_vld_pipe[MULT_LATENCY-2:0], w_accept};
                end
            end
        end
    endgenerate

    // Clear has priority over a same-cycle exceptional capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exc_count <= '0;
        end else if (exc_clr) begin
            r_exc_count <= '0;
        end else if (w_capture && fp_is_exc(w_class) && (r_exc_count != c_exc_max)) begin
            r_exc_count <= r_exc_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else if (in_valid && !issue_ready) begin
            r_drop <= 1'b1;
        end
    end

    fp_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_capture),
        .i_push_data ({w_class, y}),
        .o_valid     (out_valid),
        .i_ready     (out_ready),
        .o_data      (w_head),
        .o_occ       (w_occ)
    );

    assign out_data  = w_head[FP_WORD_W-1:0];
    assign out_class = w_head[c_entry_w-1:FP_WORD_W];
    assign exc_count = r_exc_count;
    assign drop      = r_drop;

endmodule
`default_nettype wire
